// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_CLK_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - 2-FF synchroniser for the asynchronous serial line.
// Resets to 1 so an idle-high line never looks like a start edge out of reset.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding the RX FIFO write port.
// Bad bytes are dropped and flagged by one-cycle frame/parity/overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] wr_d,
  output logic                      wr_en,
  input  logic                      wr_full,
  output logic                      frame_err,
  output logic                      overrun_err,
  output logic                      parity_err
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int H  = CLK_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_PER_BIT - 1);

  logic rx_s;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rx_s)
  );

  uart_rx_state_t            state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] wr_d_q, wr_d_d;
  logic                      wr_en_q, wr_en_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_err_q, overrun_err_d;
  logic                      par_mis;
  logic                      parity_err_d;
  logic                      cnt_full;

  assign cnt_full = (cnt_q == CNT_FULL);

`ifdef UART_RX_PARITY_EN
  logic par_mis_q, par_mis_d;
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_mis_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_mis_q    <= par_mis_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Even parity: data plus parity bit must XOR to zero.
  always_comb begin
    par_mis_d = par_mis_q;
    if (state_q == ST_PARITY && cnt_full) begin
      par_mis_d = ^{shift_q, rx_s};
    end
  end

  assign par_mis    = par_mis_q;
  assign parity_err = parity_err_q;
`else
  assign par_mis    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      wr_d_q        <= '0;
      wr_en_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      wr_d_q        <= wr_d_d;
      wr_en_q       <= wr_en_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // A start bit that is high again at mid-bit is treated as a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_full) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_full) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (cnt_full) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_d_d        = wr_d_q;
    wr_en_d       = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    parity_err_d  = 1'b0;
    if (state_q == ST_STOP && cnt_full) begin
      if (!rx_s) begin
        frame_err_d = 1'b1;
      end else if (par_mis) begin
        parity_err_d = 1'b1;
      end else if (wr_full) begin
        overrun_err_d = 1'b1;
      end else begin
        wr_en_d = 1'b1;
        wr_d_d  = shift_q;
      end
    end
  end

  assign wr_d        = wr_d_q;
  assign wr_en       = wr_en_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at CLK_PER_BIT=16 (8N1, or 8E1 with UART_RX_PARITY_EN).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int K_WRITE = 0;
  localparam int K_FRAME = 1;
  localparam int K_OVER  = 2;
  localparam int K_PAR   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       wr_full = 1'b0;
  logic [7:0] wr_d;
  logic       wr_en, frame_err, overrun_err, parity_err;

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .wr_d        (wr_d),
    .wr_en       (wr_en),
    .wr_full     (wr_full),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         kind;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    bit         stopv;
    bit         full;
    int         hold;
    int         gap;
    int         exp_kind;
  } vec_t;

  exp_t       expq[$];
  logic [7:0] model_wr_d = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Outcome of one frame, straight from the line-error priority rules.
  function automatic int predict(input bit par_bad, input bit stopv, input bit full);
    if (!stopv) return K_FRAME;
    if (PBITS == 1 && par_bad) return K_PAR;
    if (full) return K_OVER;
    return K_WRITE;
  endfunction

  always @(negedge clk) begin
    int   nact;
    int   k;
    exp_t e;
    if (rst) model_wr_d = 8'h00;
    nact = int'(wr_en) + int'(frame_err) + int'(overrun_err) + int'(parity_err);
    if (nact > 1) check("one_pulse_per_cycle", nact, 1);
    if (nact == 1) begin
      k = wr_en ? K_WRITE : frame_err ? K_FRAME : overrun_err ? K_OVER : K_PAR;
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required none", k, cyc);
      end else begin
        e = expq.pop_front();
        check("pulse_kind", k, e.kind);
        check("pulse_cycle", cyc, e.cyc);
        if (e.kind == K_WRITE) model_wr_d = e.d;
        check("wr_d", wr_d, model_wr_d);
      end
    end
  end

  task automatic cyc_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_wait();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stopv, input bit full,
                            input int hold, input int gap, input int exp_kind);
    exp_t e;
    e.kind = exp_kind;
    e.d    = d;
    e.cyc  = cyc + 2 + H + (9 + PBITS) * CPB + 1;
    expq.push_back(e);
    wr_full = full;
    rxd = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      bit_wait();
    end
    if (PBITS == 1) begin
      rxd = ^d ^ par_bad;
      bit_wait();
    end
    rxd = stopv;
    bit_wait();
    repeat (hold) cyc_wait();
    rxd = 1'b1;
    repeat (gap) cyc_wait();
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'h55, 1'b1, 1'b0, 0,  5, K_WRITE};
    tbl[1] = '{8'hA3, 1'b0, 1'b0, 40, 5, K_FRAME};
    tbl[2] = '{8'h81, 1'b1, 1'b0, 0,  3, K_WRITE};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 0,  4, K_OVER};
    tbl[4] = '{8'h00, 1'b1, 1'b0, 0,  0, K_WRITE};
    tbl[5] = '{8'hFF, 1'b1, 1'b0, 0,  0, K_WRITE};
    tbl[6] = '{8'h80, 1'b1, 1'b0, 0,  0, K_WRITE};
    tbl[7] = '{8'h5A, 1'b0, 1'b1, 0,  6, K_FRAME};

    repeat (3) cyc_wait();
    check("rst_wr_d", wr_d, 8'h00);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun_err", overrun_err, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (5) cyc_wait();

    for (int i = 0; i < 8; i++)
      send_frame(tbl[i].d, 1'b0, tbl[i].stopv, tbl[i].full, tbl[i].hold, tbl[i].gap, tbl[i].exp_kind);
    wr_full = 1'b0;

    // Short low glitch must not start a frame.
    rxd = 1'b0;
    repeat (4) cyc_wait();
    rxd = 1'b1;
    repeat (30) cyc_wait();
    check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0, 4, K_WRITE);

    // Reset in the middle of data bit 4 of 0xF0.
    rxd = 1'b0;
    bit_wait();
    for (int i = 0; i < 4; i++) bit_wait();
    rxd = 1'b1;
    repeat (H) cyc_wait();
    rst = 1'b1;
    cyc_wait();
    rst = 1'b0;
    check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("midrst_wr_d", wr_d, 8'h00);
    repeat (4 * CPB) cyc_wait();
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, 0, 4, K_WRITE);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, 0, 4, K_WRITE);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0, 4, K_PAR);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 0, 4, K_PAR);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      bit         stopv, full, par_bad;
      int         gap;
      d       = 8'($urandom);
      stopv   = ($urandom_range(0, 7) != 0);
      full    = ($urandom_range(0, 3) == 0);
      par_bad = ($urandom_range(0, 7) == 0);
      gap     = $urandom_range(0, 12);
      if (!stopv && gap < 2) gap = 2;
      send_frame(d, par_bad, stopv, full, 0, gap, predict(par_bad, stopv, full));
    end
    wr_full = 1'b0;

    for (int i = 0; i < 400 && expq.size() != 0; i++) cyc_wait();
    check("pending_pulses", expq.size(), 0);
    repeat (20) cyc_wait();
    check("final_state", 32'(dut.state_q), 32'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
